controlador_hamming: RTL and testbench

- Sequencer for the Hamming SEC/DED chain: Codificador -> Decodificador -> Correccion_de_error -> mux -> display7.
- Accepts one transaction at a time: a 4-bit data word plus an 8-bit received word that may be corrupted.
- Drives the transaction into the datapath and waits the fixed pipeline latency, then captures the corrected result and error flags.
- Afterwards it schedules the display mux selector, either rotating automatically or following a manual selection, and keeps saturating error statistics.

---
 rtl/hamming_pkg.sv | 33 +++
 rtl/controlador_hamming_if.sv | 40 ++++
 rtl/controlador_hamming_rotador_mux.sv | 61 ++++++
 rtl/controlador_hamming.sv | 110 +++++++++++
 tb/tb_controlador_hamming.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SEC/DED chain: widths, display-mux codes and
// the sequencer state type.
package hamming_pkg;

  localparam int unsigned DATO_W    = 4;
  localparam int unsigned PALABRA_W = 8;

  localparam logic [1:0] MUX_CORR = 2'b01;
  localparam logic [1:0] MUX_RX   = 2'b10;
  localparam logic [1:0] MUX_SIND = 2'b11;

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    CARGA   = 3'd1,
    ESPERA  = 3'd2,
    CAPTURA = 3'd3,
    MOSTRAR = 3'd4
  } estado_t;

  // 00 is not a valid display mode; it falls back to the corrected-data view.
  function automatic logic [1:0] sel_a_mux(input logic [1:0] sel);
    return (sel == 2'b00) ? MUX_CORR : sel;
  endfunction

  function automatic logic [1:0] mux_siguiente(input logic [1:0] m);
    case (m)
      MUX_CORR: return MUX_RX;
      MUX_RX:   return MUX_SIND;
      default:  return MUX_CORR;
    endcase
  endfunction

endpackage

// File: rtl/controlador_hamming_if.sv
// Bundle of host-side controls and datapath connections of the Hamming sequencer.
// master = host/datapath side, slave = the sequencer.
interface controlador_hamming_if
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);
  logic                 inicio;
  logic [DATO_W-1:0]    dato_in;
  logic [PALABRA_W-1:0] rx_in;
  logic                 modo_auto;
  logic [1:0]           sel_manual;
  logic                 simplerror_detectado;
  logic                 doblerror_detectado;
  logic [DATO_W-1:0]    corregido;
  logic [DATO_W-1:0]    dato_entrada;
  logic [PALABRA_W-1:0] dato_error;
  logic [1:0]           e_mux;
  logic                 ocupado;
  logic                 listo;
  logic [DATO_W-1:0]    resultado;
  logic                 led_doblerror;
  logic [CNT_W-1:0]     cnt_simple;
  logic [CNT_W-1:0]     cnt_doble;

  modport master (
    output inicio, dato_in, rx_in, modo_auto, sel_manual,
    output simplerror_detectado, doblerror_detectado, corregido,
    input  dato_entrada, dato_error, e_mux, ocupado, listo, resultado, led_doblerror,
    input  cnt_simple, cnt_doble
  );

  modport slave (
    input  inicio, dato_in, rx_in, modo_auto, sel_manual,
    input  simplerror_detectado, doblerror_detectado, corregido,
    output dato_entrada, dato_error, e_mux, ocupado, listo, resultado, led_doblerror,
    output cnt_simple, cnt_doble
  );

endinterface

// File: rtl/controlador_hamming_rotador_mux.sv
// Display mux scheduler: rotates 01->10->11 every T_ROTA cycles or follows a
// registered manual selection.
module rotador_mux
  import hamming_pkg::*;
#(
  parameter int unsigned T_ROTA = 50_000_000
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       arranque_i,
  input  logic       en_i,
  input  logic       modo_auto_i,
  input  logic [1:0] sel_manual_i,
  output logic [1:0] e_mux_o
);

  localparam int unsigned TimerW = (T_ROTA > 1) ? $clog2(T_ROTA) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(T_ROTA - 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        e_mux_q, e_mux_d;
  logic              modo_q;

  always_comb begin
    timer_d = timer_q;
    e_mux_d = e_mux_q;
    if (arranque_i) begin
      timer_d = '0;
      e_mux_d = modo_auto_i ? MUX_CORR : sel_a_mux(sel_manual_i);
    end else if (en_i) begin
      if (!modo_auto_i) begin
        timer_d = '0;
        e_mux_d = sel_a_mux(sel_manual_i);
      end else if (!modo_q) begin
        // Returning from manual mode restarts the rotation from the beginning.
        timer_d = '0;
        e_mux_d = MUX_CORR;
      end else if (timer_q == TimerMax) begin
        timer_d = '0;
        e_mux_d = mux_siguiente(e_mux_q);
      end else begin
        timer_d = timer_q + TimerW'(1);
      end
    end
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      e_mux_q <= MUX_CORR;
      modo_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      e_mux_q <= e_mux_d;
      modo_q  <= modo_auto_i;
    end
  end

  assign e_mux_o = e_mux_q;

endmodule

// File: rtl/controlador_hamming.sv
// Transaction sequencer for the Hamming encode/decode/correct datapath: drives one
// word pair, waits the datapath latency, captures results and keeps error counts.
module controlador_hamming
  import hamming_pkg::*;
#(
  parameter int unsigned LATENCIA = 3,
  parameter int unsigned T_ROTA   = 50_000_000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  reloj,
  input  logic                  reset,
  controlador_hamming_if.slave  bus
);

  estado_t              estado_q, estado_d;
  logic [3:0]           espera_q, espera_d;
  logic [DATO_W-1:0]    dato_entrada_q, dato_entrada_d;
  logic [PALABRA_W-1:0] dato_error_q, dato_error_d;
  logic [DATO_W-1:0]    resultado_q, resultado_d;
  logic                 led_q, led_d;
  logic [CNT_W-1:0]     cnt_simple_q, cnt_simple_d;
  logic [CNT_W-1:0]     cnt_doble_q, cnt_doble_d;
  logic                 listo_q;

  always_comb begin
    estado_d       = estado_q;
    espera_d       = espera_q;
    dato_entrada_d = dato_entrada_q;
    dato_error_d   = dato_error_q;
    resultado_d    = resultado_q;
    led_d          = led_q;
    cnt_simple_d   = cnt_simple_q;
    cnt_doble_d    = cnt_doble_q;
    unique case (estado_q)
      REPOSO, MOSTRAR: begin
        if (bus.inicio) begin
          estado_d       = CARGA;
          dato_entrada_d = bus.dato_in;
          dato_error_d   = bus.rx_in;
        end
      end
      CARGA: begin
        espera_d = 4'(LATENCIA - 1);
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (espera_q == 4'd0) estado_d = CAPTURA;
        else                  espera_d = espera_q - 4'd1;
      end
      CAPTURA: begin
        resultado_d = bus.corregido;
        led_d       = bus.doblerror_detectado;
        // A double error hides any single-error flag; only one counter moves.
        if (bus.doblerror_detectado) begin
          if (cnt_doble_q != '1) cnt_doble_d = cnt_doble_q + CNT_W'(1);
        end else if (bus.simplerror_detectado) begin
          if (cnt_simple_q != '1) cnt_simple_d = cnt_simple_q + CNT_W'(1);
        end
        estado_d = MOSTRAR;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado_q       <= REPOSO;
      espera_q       <= '0;
      dato_entrada_q <= '0;
      dato_error_q   <= '0;
      resultado_q    <= '0;
      led_q          <= 1'b0;
      cnt_simple_q   <= '0;
      cnt_doble_q    <= '0;
      listo_q        <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      espera_q       <= espera_d;
      dato_entrada_q <= dato_entrada_d;
      dato_error_q   <= dato_error_d;
      resultado_q    <= resultado_d;
      led_q          <= led_d;
      cnt_simple_q   <= cnt_simple_d;
      cnt_doble_q    <= cnt_doble_d;
      listo_q        <= (estado_q == CAPTURA);
    end
  end

  rotador_mux #(
    .T_ROTA (T_ROTA)
  ) u_rotador (
    .reloj        (reloj),
    .reset        (reset),
    .arranque_i   (estado_q == CAPTURA),
    .en_i         (estado_q == MOSTRAR),
    .modo_auto_i  (bus.modo_auto),
    .sel_manual_i (bus.sel_manual),
    .e_mux_o      (bus.e_mux)
  );

  assign bus.dato_entrada  = dato_entrada_q;
  assign bus.dato_error    = dato_error_q;
  assign bus.resultado     = resultado_q;
  assign bus.led_doblerror = led_q;
  assign bus.cnt_simple    = cnt_simple_q;
  assign bus.cnt_doble     = cnt_doble_q;
  assign bus.listo         = listo_q;
  assign bus.ocupado       = (estado_q == CARGA) || (estado_q == ESPERA) || (estado_q == CAPTURA);

endmodule

// File: tb/tb_controlador_hamming.sv
// Directed bench for controlador_hamming with a 3-cycle SEC/DED datapath stand-in.
module tb_controlador_hamming;

  logic reloj = 1'b0;
  logic reset = 1'b1;
  int   nchk  = 0;
  int   nfail = 0;
  logic forzar = 1'b0;

  controlador_hamming_if #(.CNT_W(2)) bus ();

  controlador_hamming #(
    .LATENCIA (3),
    .T_ROTA   (4),
    .CNT_W    (2)
  ) dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus)
  );

  always #5 reloj = ~reloj;

  // Datapath stand-in: three register stages then an (8,4) SEC/DED decode.
  // Layout: w[7:1] Hamming(7,4) positions 7..1 (data at 3,5,6,7), w[0] overall parity.
  logic [7:0] pipe0, pipe1, pipe2, wc;
  logic [2:0] sind;
  logic       par, m_simple, m_doble;

  always @(posedge reloj) begin
    pipe0 <= bus.dato_error;
    pipe1 <= pipe0;
    pipe2 <= pipe1;
  end

  always_comb begin
    sind = {pipe2[4] ^ pipe2[5] ^ pipe2[6] ^ pipe2[7],
            pipe2[2] ^ pipe2[3] ^ pipe2[6] ^ pipe2[7],
            pipe2[1] ^ pipe2[3] ^ pipe2[5] ^ pipe2[7]};
    par      = ^pipe2;
    wc       = pipe2;
    m_simple = 1'b0;
    m_doble  = 1'b0;
    if (par) begin
      m_simple = 1'b1;
      if (sind != 3'd0) wc[sind] = ~wc[sind];
    end else if (sind != 3'd0) begin
      m_doble = 1'b1;
    end
  end

  assign bus.corregido            = {wc[7], wc[6], wc[5], wc[3]};
  assign bus.simplerror_detectado = m_simple | forzar;
  assign bus.doblerror_detectado  = m_doble | forzar;

  logic [1:0] esp_rot [13] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
  int ciclos;

  // Pulses inicio and returns the number of edges until listo is seen (cap 20).
  task automatic run_txn(input logic [3:0] d, input logic [7:0] rx, output int n);
    @(negedge reloj);
    bus.inicio  = 1'b1;
    bus.dato_in = d;
    bus.rx_in   = rx;
    n = 0;
    do begin
      @(posedge reloj); #1;
      bus.inicio = 1'b0;
      n++;
    end while (!bus.listo && n < 20);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge reloj);
    #1;
    nchk++; if (bus.e_mux !== 2'b01) begin nfail++; $display("FAIL reset_e_mux got %b want 01", bus.e_mux); end
    nchk++; if (bus.ocupado !== 1'b0) begin nfail++; $display("FAIL reset_ocupado got %b want 0", bus.ocupado); end
    nchk++; if (bus.listo !== 1'b0) begin nfail++; $display("FAIL reset_listo got %b want 0", bus.listo); end
    nchk++; if (bus.resultado !== 4'd0) begin nfail++; $display("FAIL reset_resultado got %h want 0", bus.resultado); end
    nchk++; if (bus.dato_error !== 8'd0) begin nfail++; $display("FAIL reset_dato_error got %h want 0", bus.dato_error); end
    nchk++; if (bus.cnt_simple !== 2'd0 || bus.cnt_doble !== 2'd0) begin
      nfail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.cnt_simple, bus.cnt_doble); end
    @(negedge reloj);
    reset = 1'b0;
  endtask

  task automatic test_sin_error();
    bus.modo_auto = 1'b0; bus.sel_manual = 2'b01;
    run_txn(4'b1010, 8'hA5, ciclos);
    nchk++; if (ciclos != 6) begin nfail++; $display("FAIL noerr_latency got %0d want 6", ciclos); end
    nchk++; if (bus.resultado !== 4'b1010) begin nfail++; $display("FAIL noerr_resultado got %b want 1010", bus.resultado); end
    nchk++; if (bus.led_doblerror !== 1'b0) begin nfail++; $display("FAIL noerr_led got %b want 0", bus.led_doblerror); end
    nchk++; if (bus.cnt_simple !== 2'd0 || bus.cnt_doble !== 2'd0) begin
      nfail++; $display("FAIL noerr_cnt got %0d/%0d want 0/0", bus.cnt_simple, bus.cnt_doble); end
    nchk++; if (bus.dato_entrada !== 4'b1010 || bus.dato_error !== 8'hA5) begin
      nfail++; $display("FAIL noerr_drive got %b/%h want 1010/a5", bus.dato_entrada, bus.dato_error); end
    @(posedge reloj); #1;
    nchk++; if (bus.listo !== 1'b0) begin nfail++; $display("FAIL noerr_listo_pulse got %b want 0", bus.listo); end
    nchk++; if (bus.ocupado !== 1'b0) begin nfail++; $display("FAIL noerr_ocupado got %b want 0", bus.ocupado); end
  endtask

  task automatic test_error_simple();
    run_txn(4'b0010, 8'h37, ciclos);
    nchk++; if (bus.resultado !== 4'b0010) begin nfail++; $display("FAIL single_resultado got %b want 0010", bus.resultado); end
    nchk++; if (bus.cnt_simple !== 2'd1 || bus.cnt_doble !== 2'd0) begin
      nfail++; $display("FAIL single_cnt got %0d/%0d want 1/0", bus.cnt_simple, bus.cnt_doble); end
    nchk++; if (bus.led_doblerror !== 1'b0) begin nfail++; $display("FAIL single_led got %b want 0", bus.led_doblerror); end
  endtask

  task automatic test_error_doble();
    run_txn(4'b1101, 8'hC0, ciclos);
    nchk++; if (bus.cnt_simple !== 2'd1 || bus.cnt_doble !== 2'd1) begin
      nfail++; $display("FAIL double_cnt got %0d/%0d want 1/1", bus.cnt_simple, bus.cnt_doble); end
    nchk++; if (bus.led_doblerror !== 1'b1) begin nfail++; $display("FAIL double_led got %b want 1", bus.led_doblerror); end
  endtask

  task automatic test_rotacion();
    bus.modo_auto = 1'b1;
    run_txn(4'b0010, 8'h33, ciclos);
    nchk++; if (bus.led_doblerror !== 1'b0) begin nfail++; $display("FAIL rot_led_update got %b want 0", bus.led_doblerror); end
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin @(posedge reloj); #1; end
      nchk++; if (bus.e_mux !== esp_rot[i]) begin
        nfail++; $display("FAIL rot_seq[%0d] got %b want %b", i, bus.e_mux, esp_rot[i]); end
    end
    bus.modo_auto = 1'b0; bus.sel_manual = 2'b10;
    @(posedge reloj); #1;
    nchk++; if (bus.e_mux !== 2'b10) begin nfail++; $display("FAIL manual_10 got %b want 10", bus.e_mux); end
    bus.sel_manual = 2'b00;
    @(posedge reloj); #1;
    nchk++; if (bus.e_mux !== 2'b01) begin nfail++; $display("FAIL manual_00 got %b want 01", bus.e_mux); end
    bus.sel_manual = 2'b11;
    @(posedge reloj); #1;
    bus.modo_auto = 1'b1;
    @(posedge reloj); #1;
    nchk++; if (bus.e_mux !== 2'b01) begin nfail++; $display("FAIL auto_restart got %b want 01", bus.e_mux); end
    repeat (3) @(posedge reloj);
    #1;
    nchk++; if (bus.e_mux !== 2'b01) begin nfail++; $display("FAIL auto_hold got %b want 01", bus.e_mux); end
    @(posedge reloj); #1;
    nchk++; if (bus.e_mux !== 2'b10) begin nfail++; $display("FAIL auto_step got %b want 10", bus.e_mux); end
    bus.modo_auto = 1'b0;
    @(posedge reloj); #1;
  endtask

  task automatic test_ocupado_reset();
    @(negedge reloj);
    bus.inicio = 1'b1; bus.dato_in = 4'b1010; bus.rx_in = 8'hA5;
    @(posedge reloj); #1;
    bus.inicio = 1'b0;
    nchk++; if (bus.ocupado !== 1'b1) begin nfail++; $display("FAIL busy_carga got %b want 1", bus.ocupado); end
    nchk++; if (bus.e_mux !== 2'b11) begin nfail++; $display("FAIL busy_emux_hold got %b want 11", bus.e_mux); end
    @(posedge reloj);
    @(negedge reloj);
    bus.inicio = 1'b1; bus.dato_in = 4'b0101; bus.rx_in = 8'hFF;
    @(posedge reloj); #1;
    bus.inicio = 1'b0;
    nchk++; if (bus.dato_error !== 8'hA5 || bus.dato_entrada !== 4'b1010) begin
      nfail++; $display("FAIL busy_ignore got %h/%b want a5/1010", bus.dato_error, bus.dato_entrada); end
    @(negedge reloj);
    reset = 1'b1;
    #1;
    nchk++; if (bus.ocupado !== 1'b0 || bus.listo !== 1'b0 || bus.led_doblerror !== 1'b0) begin
      nfail++; $display("FAIL async_flags got %b%b%b want 000", bus.ocupado, bus.listo, bus.led_doblerror); end
    nchk++; if (bus.e_mux !== 2'b01) begin nfail++; $display("FAIL async_e_mux got %b want 01", bus.e_mux); end
    nchk++; if (bus.resultado !== 4'd0 || bus.dato_entrada !== 4'd0 || bus.dato_error !== 8'd0) begin
      nfail++; $display("FAIL async_data got %b/%b/%h want 0/0/0", bus.resultado, bus.dato_entrada, bus.dato_error); end
    nchk++; if (bus.cnt_simple !== 2'd0 || bus.cnt_doble !== 2'd0) begin
      nfail++; $display("FAIL async_cnt got %0d/%0d want 0/0", bus.cnt_simple, bus.cnt_doble); end
    @(negedge reloj);
    reset = 1'b0;
    run_txn(4'b1010, 8'hA5, ciclos);
    nchk++; if (ciclos != 6) begin nfail++; $display("FAIL post_reset_latency got %0d want 6", ciclos); end
    nchk++; if (bus.resultado !== 4'b1010) begin nfail++; $display("FAIL post_reset_resultado got %b want 1010", bus.resultado); end
  endtask

  task automatic test_saturacion();
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b0010, 8'h37, ciclos);
      nchk++; if (bus.cnt_simple !== 2'((i < 2) ? i + 1 : 3)) begin
        nfail++; $display("FAIL sat_simple[%0d] got %0d want %0d", i, bus.cnt_simple, (i < 2) ? i + 1 : 3); end
    end
    forzar = 1'b1;
    run_txn(4'b1010, 8'hA5, ciclos);
    forzar = 1'b0;
    nchk++; if (bus.cnt_doble !== 2'd1 || bus.cnt_simple !== 2'd3) begin
      nfail++; $display("FAIL both_flags got %0d/%0d want 3/1", bus.cnt_simple, bus.cnt_doble); end
    nchk++; if (bus.led_doblerror !== 1'b1) begin nfail++; $display("FAIL both_led got %b want 1", bus.led_doblerror); end
  endtask

  initial begin
    bus.inicio = 1'b0; bus.dato_in = '0; bus.rx_in = '0;
    bus.modo_auto = 1'b0; bus.sel_manual = 2'b01;
    test_reset();
    test_sin_error();
    test_error_simple();
    test_error_doble();
    test_rotacion();
    test_ocupado_reset();
    test_saturacion();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
